// File: rtl/fpga_config_loader_if.sv
// Word-stream handshake into the configuration loader.
// The source drives data and valid. The loader returns ready.
interface fpga_config_loader_if #(
    parameter int unsigned IN_W = 16
);
    logic [IN_W-1:0] in_data;
    logic            in_valid;
    logic            in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/fpga_config_loader.sv
// Assembles groups of stream words into tile configuration words.
// Each word is strobed one-hot into the tile grid, and the load closes with an XOR checksum check.
module fpga_config_loader #(
    parameter int unsigned NUM_TILES = 4,
    parameter int unsigned CFG_W     = 77,
    parameter int unsigned IN_W      = 16,
    localparam int unsigned TW       = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    fpga_config_loader_if.slave   in_if,
    output logic [CFG_W-1:0]      cfg_bits,
    output logic [NUM_TILES-1:0]  cfg_wr_en,
    output logic [TW-1:0]         tile_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int unsigned NWORDS = (CFG_W + IN_W - 1) / IN_W;
    localparam int unsigned ASM_W  = NWORDS * IN_W;
    localparam int unsigned WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                 state_q,     state_d;
    logic [TW-1:0]          tile_idx_q,  tile_idx_d;
    logic [WCW-1:0]         wcnt_q,      wcnt_d;
    logic [IN_W-1:0]        xacc_q,      xacc_d;
    logic [ASM_W-1:0]       asm_q,       asm_d;
    logic [CFG_W-1:0]       cfg_bits_q,  cfg_bits_d;
    logic [NUM_TILES-1:0]   cfg_wr_en_q, cfg_wr_en_d;
    logic                   err_q,       err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tile_idx_q  <= '0;
            wcnt_q      <= '0;
            xacc_q      <= '0;
            asm_q       <= '0;
            cfg_bits_q  <= '0;
            cfg_wr_en_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tile_idx_q  <= tile_idx_d;
            wcnt_q      <= wcnt_d;
            xacc_q      <= xacc_d;
            asm_q       <= asm_d;
            cfg_bits_q  <= cfg_bits_d;
            cfg_wr_en_q <= cfg_wr_en_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tile_idx_d  = tile_idx_q;
        wcnt_d      = wcnt_q;
        xacc_d      = xacc_q;
        asm_d       = asm_q;
        cfg_bits_d  = cfg_bits_q;
        cfg_wr_en_d = '0;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    tile_idx_d = '0;
                    wcnt_d     = '0;
                    xacc_d     = '0;
                    err_d      = 1'b0;
                end
            end
            S_LOAD: begin
                if (in_if.in_valid) begin
                    asm_d[wcnt_q * IN_W +: IN_W] = in_if.in_data;
                    xacc_d = xacc_q ^ in_if.in_data;
                    // The last word goes straight into the strobe register, so the write lands the cycle after its handshake.
                    if (wcnt_q == WCW'(NWORDS - 1)) begin
                        wcnt_d      = '0;
                        state_d     = S_WRITE;
                        cfg_bits_d  = asm_d[CFG_W-1:0];
                        cfg_wr_en_d = NUM_TILES'(1) << tile_idx_q;
                    end else begin
                        wcnt_d = wcnt_q + WCW'(1);
                    end
                end
            end
            S_WRITE: begin
                if (tile_idx_q == TW'(NUM_TILES - 1)) begin
                    state_d = S_CHECK;
                end else begin
                    tile_idx_d = tile_idx_q + TW'(1);
                    state_d    = S_LOAD;
                end
            end
            S_CHECK: begin
                if (in_if.in_valid) begin
                    if (in_if.in_data == xacc_q) begin
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_if.in_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign err            = err_q;
    assign tile_idx       = tile_idx_q;
    assign cfg_bits       = cfg_bits_q;
    assign cfg_wr_en      = cfg_wr_en_q;
endmodule

// File: tb/tb_fpga_config_loader.sv
// Randomized self-checking bench for fpga_config_loader, with a four-tile and a single-tile instance.
module tb_fpga_config_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start_a = 1'b0;
    logic start_b = 1'b0;

    fpga_config_loader_if #(.IN_W(16)) a_if ();
    fpga_config_loader_if #(.IN_W(16)) b_if ();

    logic [76:0] bits_a, bits_b;
    logic [3:0]  wr_a;
    logic [0:0]  wr_b;
    logic [1:0]  idx_a;
    logic [0:0]  idx_b;
    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;

    fpga_config_loader #(.NUM_TILES(4), .CFG_W(77), .IN_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_if(a_if),
        .cfg_bits(bits_a), .cfg_wr_en(wr_a), .tile_idx(idx_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    fpga_config_loader #(.NUM_TILES(1), .CFG_W(77), .IN_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_if(b_if),
        .cfg_bits(bits_b), .cfg_wr_en(wr_b), .tile_idx(idx_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe and done observers
    int          st_cyc[$];
    logic [3:0]  st_en[$];
    logic [76:0] st_bits[$];
    int          done_cnt_a = 0;
    int          st_b_cnt   = 0;
    logic [76:0] st_b_bits  = '0;
    int          done_cnt_b = 0;

    always @(negedge clk) begin
        if (wr_a != 0) begin
            st_cyc.push_back(cyc);
            st_en.push_back(wr_a);
            st_bits.push_back(bits_a);
        end
        if (done_a) done_cnt_a++;
        if (wr_b != 0) begin
            st_b_cnt++;
            st_b_bits = bits_b;
        end
        if (done_b) done_cnt_b++;
    end

    logic [15:0] words [20];

    task automatic send_a(input logic [15:0] d, input bit gaps);
        int n;
        bit hs;
        if (gaps) begin
            for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
                a_if.in_valid = 1'b0;
                a_if.in_data  = 16'($urandom);
                @(posedge clk); #1;
            end
        end
        a_if.in_valid = 1'b1;
        a_if.in_data  = d;
        n = 0;
        forever begin
            @(negedge clk);
            hs = a_if.in_ready;
            @(posedge clk); #1;
            if (hs) break;
            n++;
            if (n > 100) begin
                errors++;
                $display("FAIL a_ready_timeout: got no ready, expected ready within 100 cycles");
                break;
            end
        end
        a_if.in_valid = 1'b0;
        a_if.in_data  = 16'($urandom);
    endtask

    task automatic send_b(input logic [15:0] d);
        int n;
        bit hs;
        b_if.in_valid = 1'b1;
        b_if.in_data  = d;
        n = 0;
        forever begin
            @(negedge clk);
            hs = b_if.in_ready;
            @(posedge clk); #1;
            if (hs) break;
            n++;
            if (n > 100) begin
                errors++;
                $display("FAIL b_ready_timeout: got no ready, expected ready within 100 cycles");
                break;
            end
        end
        b_if.in_valid = 1'b0;
    endtask

    task automatic run_load(input bit pattern, input bit gaps, input bit bad_cs, input bit poke_start);
        logic [15:0] cs;
        logic [79:0] a;
        int s;
        int base_done;
        for (int i = 0; i < 20; i++) words[i] = pattern ? 16'(i + 1) : 16'($urandom);
        cs = '0;
        for (int i = 0; i < 20; i++) cs = cs ^ words[i];
        if (bad_cs) cs = cs ^ 16'h0001;
        st_cyc.delete();
        st_en.delete();
        st_bits.delete();
        base_done = done_cnt_a;

        start_a = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("start_busy", busy_a, 1);
        check("start_ready", a_if.in_ready, 1);
        check("start_err_clr", err_a, 0);
        check("start_idx", idx_a, 0);

        for (int i = 0; i < 20; i++) begin
            if (poke_start && i == 12) start_a = 1'b1;
            send_a(words[i], gaps);
            if (poke_start && i == 12) begin
                start_a = 1'b0;
                check("poke_idx", idx_a, 2);
                check("poke_busy", busy_a, 1);
            end
        end
        send_a(cs, gaps);

        if (bad_cs) begin
            check("bad_err", err_a, 1);
            check("bad_done", done_a, 0);
            check("bad_busy", busy_a, 0);
        end else begin
            check("ok_done", done_a, 1);
            check("ok_err", err_a, 0);
            if (!gaps) check("done_cycle", cyc - s, 26);
        end
        @(posedge clk); #1;
        check("end_busy", busy_a, 0);
        check("end_done", done_a, 0);
        check("end_err", err_a, bad_cs);
        check("done_pulses", done_cnt_a - base_done, bad_cs ? 0 : 1);

        check("strobe_count", st_en.size(), 4);
        for (int t = 0; t < 4 && t < st_en.size(); t++) begin
            a = {words[5*t+4], words[5*t+3], words[5*t+2], words[5*t+1], words[5*t]};
            check($sformatf("bits_t%0d", t), st_bits[t], a[76:0]);
            check($sformatf("wren_t%0d", t), st_en[t], 4'b0001 << t);
            if (!gaps) check($sformatf("strobe_cyc_t%0d", t), st_cyc[t] - s, 6 * (t + 1));
        end
        if (pattern && st_bits.size() > 0)
            check("tile0_literal", st_bits[0], {13'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        a_if.in_valid = 1'b1;
        a_if.in_data  = 16'hA5A5;
        b_if.in_valid = 1'b1;
        b_if.in_data  = 16'h5A5A;
        start_a = 1'b1;
        start_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", a_if.in_ready, 0);
        check("rst_bits", bits_a, 0);
        check("rst_wren", wr_a, 0);
        check("rst_idx", idx_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        check("rst_b_busy", busy_b, 0);
        start_a = 1'b0;
        start_b = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy_a, 0);
        check("idle_ready", a_if.in_ready, 0);
        a_if.in_valid = 1'b0;
        b_if.in_valid = 1'b0;

        run_load(1, 0, 0, 0);
        run_load(1, 0, 1, 0);
        run_load(1, 0, 0, 0);
        run_load(1, 1, 0, 0);
        repeat (3) run_load(0, 1, 0, 0);
        run_load(1, 0, 0, 1);

        // reset during the tile-1 write strobe
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int i = 0; i < 10; i++) send_a(16'($urandom), 0);
        check("pre_rst_wren", wr_a, 4'b0010);
        rst_n = 1'b0;
        #1;
        check("async_rst_wren", wr_a, 0);
        check("async_rst_busy", busy_a, 0);
        check("async_rst_bits", bits_a, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_load(0, 0, 0, 0);

        // single-tile instance with all-ones data
        st_b_cnt = 0;
        done_cnt_b = 0;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int i = 0; i < 5; i++) send_b(16'hFFFF);
        send_b(16'hFFFF);
        check("b_done", done_b, 1);
        check("b_err", err_b, 0);
        @(posedge clk); #1;
        check("b_strobes", st_b_cnt, 1);
        check("b_bits", st_b_bits, {77{1'b1}});
        check("b_done_pulses", done_cnt_b, 1);
        check("b_busy_end", busy_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
